// File: rtl/mux_rr_scheduler_pkg.sv
// Shared definitions for the round-robin mux scheduler slice.
package mux_sched_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/rr_pick8.sv
// Rotating priority encoder: first set request scanning from i_ptr upward, wrapping at 8.
module rr_pick8
  import mux_sched_pkg::*;
(
  input  logic [N_REQ-1:0] i_req,
  input  logic [SEL_W-1:0] i_ptr,
  output logic             o_valid,
  output logic [SEL_W-1:0] o_idx
);

  logic [SEL_W-1:0] w_pos;

  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    w_pos   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      w_pos = i_ptr + SEL_W'(k);
      if (!o_valid && i_req[w_pos]) begin
        o_valid = 1'b1;
        o_idx   = w_pos;
      end
    end
  end

endmodule

// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler in front of the 8:1 mux; holds a grant until release, request drop or hold limit.
module mux_rr_scheduler #(
  parameter int N_REQ    = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_REQ-1:0]               i_req,
  input  logic                           i_release,
  output logic [N_REQ-1:0]               o_grant,
  output logic [mux_sched_pkg::SEL_W-1:0] o_mux_sel,
  output logic                           o_mux_en,
  output logic                           o_busy,
  output logic                           o_hold_timeout
);

  import mux_sched_pkg::SEL_W;
  import mux_sched_pkg::state_e;
  import mux_sched_pkg::IDLE;
  import mux_sched_pkg::GRANT;

  localparam int CNT_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

  state_e           r_state;
  logic [SEL_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic [N_REQ-1:0] r_grant;
  logic [SEL_W-1:0] r_sel;
  logic             r_en;
  logic             r_timeout;

  logic             w_valid;
  logic [SEL_W-1:0] w_idx;
  logic             w_drop;
  logic             w_limit;
  logic             w_end;

  rr_pick8 u_pick (
    .i_req   (i_req),
    .i_ptr   (r_ptr),
    .o_valid (w_valid),
    .o_idx   (w_idx)
  );

  assign w_drop  = ~i_req[r_sel];
  assign w_limit = (MAX_HOLD != 0) && (r_cnt == HOLD_LAST);
  assign w_end   = i_release | w_drop | w_limit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_grant   <= '0;
      r_sel     <= '0;
      r_en      <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_state <= GRANT;
            r_grant <= N_REQ'(1) << w_idx;
            r_sel   <= w_idx;
            r_en    <= 1'b1;
            r_cnt   <= '0;
          end
        end
        GRANT: begin
          if (w_end) begin
            // mux_sel deliberately keeps the last owner while idle
            r_state   <= IDLE;
            r_grant   <= '0;
            r_en      <= 1'b0;
            r_ptr     <= r_sel + SEL_W'(1);
            r_timeout <= w_limit & ~i_release & ~w_drop;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_grant        = r_grant;
  assign o_mux_sel      = r_sel;
  assign o_mux_en       = r_en;
  assign o_busy         = r_en;
  assign o_hold_timeout = r_timeout;

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Self-checking bench for mux_rr_scheduler with a grant-length based reference model.
module tb_mux_rr_scheduler;

  localparam int MH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] i_req = '0;
  logic       i_release = 1'b0;
  logic [7:0] o_grant;
  logic [2:0] o_mux_sel;
  logic       o_mux_en;
  logic       o_busy;
  logic       o_hold_timeout;

  int vectors = 0;
  int errors  = 0;

  // reference model state: owner and how many cycles it has held the mux
  bit       m_busy;
  bit       m_to;
  int       m_ptr;
  int       m_owner;
  int       m_len;
  logic [2:0] m_sel;

  mux_rr_scheduler #(.N_REQ(8), .MAX_HOLD(MH)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_req          (i_req),
    .i_release      (i_release),
    .o_grant        (o_grant),
    .o_mux_sel      (o_mux_sel),
    .o_mux_en       (o_mux_en),
    .o_busy         (o_busy),
    .o_hold_timeout (o_hold_timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] m_grant();
    return m_busy ? (8'd1 << m_owner) : 8'd0;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_to = 0; m_ptr = 0; m_owner = 0; m_len = 0; m_sel = '0;
  endtask

  task automatic model_step(input logic [7:0] rq, input logic rel);
    bit fin;
    if (!m_busy) begin
      m_to = 0;
      for (int k = 0; k < 8; k++) begin
        int c;
        c = (m_ptr + k) % 8;
        if (rq[c]) begin
          m_busy = 1; m_owner = c; m_sel = 3'(c); m_len = 1;
          break;
        end
      end
    end else begin
      fin  = rel || !rq[m_owner] || (MH != 0 && m_len == MH);
      m_to = fin && !rel && rq[m_owner];
      if (fin) begin
        m_busy = 0;
        m_ptr  = (m_owner + 1) % 8;
      end else begin
        m_len++;
      end
    end
  endtask

  task automatic step(input logic [7:0] rq, input logic rel);
    i_req = rq;
    i_release = rel;
    @(posedge clk);
    model_step(rq, rel);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_req = '0;
    i_release = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    model_reset();
    @(negedge clk);
    vectors++;
    if ({o_grant, o_mux_sel, o_mux_en, o_busy, o_hold_timeout} !== 14'd0) begin
      errors++;
      $display("FAIL reset_state: got grant=%h sel=%0d en=%b busy=%b to=%b, want all 0",
               o_grant, o_mux_sel, o_mux_en, o_busy, o_hold_timeout);
    end
    rst = 1'b0;
    step(8'h08, 1'b0);
    vectors++;
    if (o_grant !== 8'h08 || o_mux_sel !== 3'd3) begin
      errors++;
      $display("FAIL reset_grant3: got grant=%h sel=%0d, want 08 sel=3", o_grant, o_mux_sel);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (o_grant !== 8'h00 || o_mux_en !== 1'b0 || o_hold_timeout !== 1'b0 || o_mux_sel !== 3'd0) begin
      errors++;
      $display("FAIL reset_async: got grant=%h en=%b to=%b sel=%0d, want 00 0 0 0",
               o_grant, o_mux_en, o_hold_timeout, o_mux_sel);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(8'hFF, 1'b0);
    vectors++;
    if (o_grant !== 8'h01 || o_mux_sel !== 3'd0 || o_mux_en !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_grant: got grant=%h sel=%0d en=%b, want 01 0 1",
               o_grant, o_mux_sel, o_mux_en);
    end
  endtask

  task automatic test_round_robin();
    int exp_sel;
    do_reset();
    for (int k = 0; k < 18; k++) begin
      step(8'hFF, (k % 2) == 1);
      exp_sel = (k / 2) % 8;
      vectors++;
      if ((k % 2) == 0) begin
        if (o_mux_en !== 1'b1 || o_mux_sel !== 3'(exp_sel) || o_grant !== (8'd1 << exp_sel)) begin
          errors++;
          $display("FAIL rr_grant[%0d]: got en=%b sel=%0d grant=%h, want en=1 sel=%0d",
                   k, o_mux_en, o_mux_sel, o_grant, exp_sel);
        end
      end else if (o_mux_en !== 1'b0 || o_grant !== 8'h00 || o_mux_sel !== 3'(exp_sel)) begin
        errors++;
        $display("FAIL rr_bubble[%0d]: got en=%b grant=%h sel=%0d, want en=0 grant=00 sel=%0d",
                 k, o_mux_en, o_grant, o_mux_sel, exp_sel);
      end
    end
  endtask

  task automatic test_wrap_skip();
    do_reset();
    step(8'h04, 1'b0);
    step(8'h04, 1'b1);
    step(8'h84, 1'b1);
    vectors++;
    if (o_grant !== 8'h80 || o_mux_sel !== 3'd7) begin
      errors++;
      $display("FAIL wrap_to7: got grant=%h sel=%0d, want 80 sel=7", o_grant, o_mux_sel);
    end
    step(8'h84, 1'b1);
    step(8'h84, 1'b0);
    vectors++;
    if (o_grant !== 8'h04 || o_mux_sel !== 3'd2) begin
      errors++;
      $display("FAIL wrap_to2: got grant=%h sel=%0d, want 04 sel=2", o_grant, o_mux_sel);
    end
  endtask

  task automatic test_hold_limit();
    int cnt;
    int to_seen;
    do_reset();
    step(8'h20, 1'b0);
    cnt = 1;
    to_seen = 0;
    for (int k = 0; k < 40; k++) begin
      step(8'h20, 1'b0);
      if (o_hold_timeout === 1'b1) to_seen++;
      if (o_mux_en !== 1'b1) break;
      cnt++;
    end
    vectors++;
    if (cnt !== MH || o_hold_timeout !== 1'b1 || to_seen !== 1 || o_grant !== 8'h00) begin
      errors++;
      $display("FAIL hold_limit: got len=%0d to=%b pulses=%0d grant=%h, want len=%0d to=1 pulses=1 grant=00",
               cnt, o_hold_timeout, to_seen, o_grant, MH);
    end
    step(8'h20, 1'b0);
    vectors++;
    if (o_mux_en !== 1'b1 || o_mux_sel !== 3'd5 || o_hold_timeout !== 1'b0) begin
      errors++;
      $display("FAIL hold_regrant: got en=%b sel=%0d to=%b, want 1 5 0", o_mux_en, o_mux_sel, o_hold_timeout);
    end
  endtask

  task automatic test_early_drop();
    do_reset();
    step(8'h10, 1'b0);
    step(8'h10, 1'b0);
    vectors++;
    if (o_mux_en !== 1'b1 || o_mux_sel !== 3'd4) begin
      errors++;
      $display("FAIL drop_hold: got en=%b sel=%0d, want 1 4", o_mux_en, o_mux_sel);
    end
    step(8'h00, 1'b0);
    vectors++;
    if (o_mux_en !== 1'b0 || o_hold_timeout !== 1'b0 || o_mux_sel !== 3'd4) begin
      errors++;
      $display("FAIL drop_end: got en=%b to=%b sel=%0d, want 0 0 4", o_mux_en, o_hold_timeout, o_mux_sel);
    end
    step(8'h30, 1'b0);
    vectors++;
    if (o_grant !== 8'h20 || o_mux_sel !== 3'd5) begin
      errors++;
      $display("FAIL drop_ptr5: got grant=%h sel=%0d, want 20 5", o_grant, o_mux_sel);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    step(8'h20, 1'b0);
    for (int k = 0; k < MH - 1; k++) step(8'h20, 1'b0);
    vectors++;
    if (o_mux_en !== 1'b1) begin
      errors++;
      $display("FAIL simul_still_held: got en=%b, want 1", o_mux_en);
    end
    step(8'h20, 1'b1);
    vectors++;
    if (o_mux_en !== 1'b0 || o_hold_timeout !== 1'b0) begin
      errors++;
      $display("FAIL simul_end: got en=%b to=%b, want 0 0", o_mux_en, o_hold_timeout);
    end
  endtask

  task automatic test_random();
    logic [7:0] rq;
    logic       rel;
    do_reset();
    rq = 8'($urandom);
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 11) == 0) rq = 8'($urandom) & 8'($urandom);
      rel = ($urandom_range(0, 9) == 0);
      step(rq, rel);
      vectors++;
      if (o_grant !== m_grant() || o_mux_sel !== m_sel || o_mux_en !== m_busy ||
          o_busy !== m_busy || o_hold_timeout !== m_to) begin
        errors++;
        $display("FAIL random[%0d]: got grant=%h sel=%0d en=%b busy=%b to=%b, want grant=%h sel=%0d en=%b to=%b",
                 k, o_grant, o_mux_sel, o_mux_en, o_busy, o_hold_timeout,
                 m_grant(), m_sel, m_busy, m_to);
      end
      vectors++;
      if (!$onehot0(o_grant) || (o_mux_en !== (|o_grant))) begin
        errors++;
        $display("FAIL invariant[%0d]: got grant=%h en=%b, want one-hot-or-zero with en==|grant",
                 k, o_grant, o_mux_en);
      end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_wrap_skip();
    test_hold_limit();
    test_early_drop();
    test_simultaneous();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
